// File: rtl/counter.sv
// Iteration counter for the shift-add multiplier: pulses `flag` after WORD_LENGTH enabled cycles.
// Optional build macro COUNTER_STICKY_FLAG_EN makes `flag` hold until reset instead of pulsing.
module counter #(
  parameter int WORD_LENGTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic flag
);

  localparam int WORD  = 2 * WORD_LENGTH;
  localparam int CNT_W = ($clog2(WORD_LENGTH + 1) > 1) ? $clog2(WORD_LENGTH + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_LENGTH - 1);

  // A product narrower than 2 bits means WORD_LENGTH < 1.
  if (WORD < 2) begin : g_bad_word_length
    $error("counter: WORD_LENGTH must be 1 or greater (got %0d)", WORD_LENGTH);
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             flag_q;
  logic             flag_d;
  logic             terminal;

  always_comb begin
    cnt_d    = cnt_q;
    flag_d   = 1'b0;
    terminal = (cnt_q == CNT_LAST);
`ifdef COUNTER_STICKY_FLAG_EN
    if (flag_q) begin
      // Latched done: counter frozen at zero until the next reset.
      flag_d = 1'b1;
      cnt_d  = '0;
    end else if (enable) begin
      if (terminal) begin
        cnt_d  = '0;
        flag_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`else
    if (enable) begin
      if (terminal) begin
        cnt_d  = '0;
        flag_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign flag = flag_q;

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter: WORD_LENGTH=3 and WORD_LENGTH=1 instances driven side by side.
module tb_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst3 = 1'b0, en3 = 1'b0, flag3;
  logic rst1 = 1'b0, en1 = 1'b0, flag1;

  counter #(.WORD_LENGTH(3)) u_dut3 (
    .clk    (clk),
    .reset  (rst3),
    .enable (en3),
    .flag   (flag3)
  );

  counter #(.WORD_LENGTH(1)) u_dut1 (
    .clk    (clk),
    .reset  (rst1),
    .enable (en1),
    .flag   (flag1)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    string tag;
    logic  exp3;
    logic  exp1;
  } exp_t;

  exp_t sb_q[$];

  // Reference: count enabled edges since reset; flag on every multiple of WORD_LENGTH.
  int   m_n3 = 0, m_n1 = 0;
  logic m_f3 = 1'b0, m_f1 = 1'b0;

`ifdef COUNTER_STICKY_FLAG_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  function automatic logic model_next(input int wl, input logic r, input logic e,
                                      inout int n, input logic f);
    logic nf;
    if (r) begin
      n  = 0;
      nf = 1'b0;
    end else if (STICKY && f) begin
      nf = 1'b1;
    end else if (e) begin
      n  = n + 1;
      nf = ((n % wl) == 0);
    end else begin
      nf = 1'b0;
    end
    return nf;
  endfunction

  task automatic check_bit(input string tag, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: flag got %b, expected %b", tag, act, exp);
    end
  endtask

  task automatic step(input string tag, input logic r3, input logic e3,
                      input logic r1, input logic e1);
    exp_t item;
    @(negedge clk);
    rst3 = r3; en3 = e3;
    rst1 = r1; en1 = e1;
    m_f3 = model_next(3, r3, e3, m_n3, m_f3);
    m_f1 = model_next(1, r1, e1, m_n1, m_f1);
    item.tag  = tag;
    item.exp3 = m_f3;
    item.exp1 = m_f1;
    sb_q.push_back(item);
    @(posedge clk);
    #1;
    item = sb_q.pop_front();
    check_bit({item.tag, "/wl3"}, flag3, item.exp3);
    check_bit({item.tag, "/wl1"}, flag1, item.exp1);
  endtask

  task automatic both(input string tag, input logic r, input logic e);
    step(tag, r, e, r, e);
  endtask

  initial begin
    logic gap_pat [5];
    gap_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset held with enable high, then first terminal count three edges later.
    for (int i = 0; i < 4; i++) both("rst_hold", 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) both("rst_release", 1'b0, 1'b1);

    // Continuous enable over two periods.
    both("basic_rst", 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) both("basic_count", 1'b0, 1'b1);

    // Enable gaps pause the count.
    both("gap_rst", 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) both("gap", 1'b0, gap_pat[i]);
    both("gap_idle", 1'b0, 1'b0);
    both("gap_idle2", 1'b0, 1'b0);

    // Reset mid-count discards progress.
    both("mid_rst0", 1'b1, 1'b0);
    both("mid_cnt", 1'b0, 1'b1);
    both("mid_cnt", 1'b0, 1'b1);
    both("mid_rst", 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) both("mid_resume", 1'b0, 1'b1);

    // Short run then idle: exercises the WORD_LENGTH=1 every-cycle pulse.
    both("wl1_rst", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) both("wl1_run", 1'b0, 1'b1);
    both("wl1_idle", 1'b0, 1'b0);

    // Sticky plan (also valid as a pulse check in the default build).
    both("sticky_rst", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) both("sticky_cnt", 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) both("sticky_hold", 1'b0, logic'(i % 2));
    both("sticky_clear", 1'b1, 1'b0);
    both("sticky_after", 1'b0, 1'b0);

    // Random enables with occasional resets, independent per instance.
    for (int i = 0; i < 60; i++) begin
      step("random",
           logic'($urandom_range(0, 15) == 0), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 15) == 0), logic'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
